calculate_checksum: RTL and testbench
=====================================

// Module: calculate_checksum
// PURPOSE
//  Computes the 8-bit checksum of a NoC flit (types::flit_t) and checks the checksum the flit carries.
//  Outputs the computed checksum, a valid flag, and the flit with its checksum field rewritten.
//  Sits on the router/NI datapath: receive side checks incoming flits, transmit side seals outgoing flits.
//  Default build is purely combinational; an optional output register stage is selectable.
// PARAMETERS
//  REGISTERED  0  0: outputs combinational from flit_in; 1: outputs registered, 1-cycle latency
// PORTS
//  clk       in   1                 clock; used only when REGISTERED=1
//  rst       in   1                 synchronous, active-high reset; used only when REGISTERED=1
//  flit_in   in   $bits(flit_t)     flit under test: header, payload, checksum (types::checksum_t, 8b)
//  checksum  out  8                 checksum computed over header+payload of flit_in
//  is_valid  out  1                 1 when flit_in.checksum == computed checksum
//  flit_out  out  $bits(flit_t)     flit_in.header, flit_in.payload, checksum field := computed checksum
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is synchronous and active-high.
//  - body = {flit_in.header, flit_in.payload}; checksum field excluded. Width BODY_W = $bits(flit_t)-8.
//  - body is zero-padded on the MSB side to a multiple of 8 bits, then split into bytes (byte0 = body[7:0]).
//  - sum = sum of all body bytes, modulo 256; carries out of bit 7 are discarded.
//  - checksum = (8'h00 - sum) mod 256, the two's complement. Consequence: body bytes + checksum == 0 mod 256.
//  - is_valid = (flit_in.checksum == checksum). Equivalently: all body bytes + flit_in.checksum == 8'h00.
//  - flit_out.header = flit_in.header and flit_out.payload = flit_in.payload, bit-exact.
//  - flit_out.checksum = checksum. A valid input therefore passes through unchanged.
//  - Every field of the flit contributes (version, flittype, src_id, dst_id, flit_id, payload).
//    The payload union is summed as raw bits, whatever its interpretation.
//  - REGISTERED=0:
//    - no state; outputs settle in the same delta cycle as flit_in.
//    - clk and rst are ignored.
//    - X on any flit_in bit may propagate to the outputs.
//  - REGISTERED=1:
//    - outputs update on each posedge clk from the flit_in sampled at that edge (latency 1 cycle).
//    - rst high at a posedge gives checksum=8'h00, is_valid=0, flit_out='0. Reset has priority over capture.
//    - first valid capture is on the first edge after rst deasserts.
//    - reset mid-stream drops the in-flight result; no output holds stale data after reset.
//  - No handshake. Every flit_in value is evaluated; the caller qualifies it with its own valid.
//  - Implementation: adder tree or sequential-loop function over bytes; no multi-cycle paths.
// TESTING
//  1. All fields 0, flit_in.checksum=8'h00 -> checksum=8'h00, is_valid=1, flit_out==flit_in.
//  2. Only body byte0=8'h01, flit_in.checksum=8'hFF -> checksum=8'hFF, is_valid=1, flit_out==flit_in.
//  3. Same body as scenario 2, flit_in.checksum=8'h00 -> checksum=8'hFF, is_valid=0.
//     flit_out header/payload equal flit_in; flit_out.checksum=8'hFF.
//  4. Wrap-around: two body bytes 8'h80, rest 0 -> sum=8'h00, checksum=8'h00.
//     flit_in.checksum=8'h00 gives is_valid=1.
//  5. All body bits 1, checksum field 0:
//     - expected = -(N*8'hFF + partial top byte) mod 256, computed by a bench reference model.
//     - then random flits (>=1000) vs the model, checking checksum, is_valid and flit_out.
//  6. REGISTERED=1:
//     - rst=1 for 2 cycles -> outputs 0 / is_valid=0.
//     - after release, scenario 2 input appears on the outputs exactly 1 cycle later.
//     - asserting rst mid-stream clears the outputs at the next edge.

Source files
------------

// File: rtl/calculate_checksum.sv
// Purpose : 8-bit two's-complement checksum of a NoC flit body; checks the carried checksum and reseals the flit.
// Latency : 0 cycles when REGISTERED=0 (pure combinational), 1 cycle when REGISTERED=1.
// Backpressure: none; every flit_in value is evaluated, the caller qualifies it with its own valid.
// Ports: clk/rst (sync, active-high; used only when REGISTERED=1), flit_in (flit under test),
//        checksum (computed over header+payload), is_valid (carried == computed), flit_out (resealed flit).

package types;
    typedef logic [7:0] checksum_t;

    typedef struct packed {
        logic [2:0] version;
        logic [1:0] flittype;
        logic [5:0] src_id;
        logic [5:0] dst_id;
        logic [7:0] flit_id;
    } header_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } payload_mem_t;

    typedef union packed {
        logic [31:0]  raw;
        payload_mem_t mem;
    } payload_t;

    typedef struct packed {
        header_t   header;
        payload_t  payload;
        checksum_t checksum;
    } flit_t;
endpackage

module calculate_checksum #(
    parameter bit REGISTERED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  types::flit_t      flit_in,
    output types::checksum_t  checksum,
    output logic              is_valid,
    output types::flit_t      flit_out
);
    localparam int BODY_W = $bits(types::flit_t) - 8;
    localparam int NBYTES = (BODY_W + 7) / 8;
    localparam int PAD_W  = NBYTES * 8;

    // Body is zero-extended to whole bytes; carries out of bit 7 drop naturally in the 8-bit accumulator.
    function automatic types::checksum_t body_checksum(input logic [BODY_W-1:0] body);
        logic [PAD_W-1:0] padded;
        logic [7:0]       sum;
        padded = PAD_W'(body);
        sum    = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            sum = sum + padded[i*8 +: 8];
        end
        return 8'h00 - sum;
    endfunction

    logic [BODY_W-1:0] body_c;
    types::checksum_t  checksum_c;
    logic              is_valid_c;
    types::flit_t      flit_c;

    // Payload union is summed as raw bits regardless of its interpretation.
    assign body_c     = {flit_in.header, flit_in.payload};
    assign checksum_c = body_checksum(body_c);
    assign is_valid_c = (flit_in.checksum == checksum_c);

    always_comb begin
        flit_c          = flit_in;
        flit_c.checksum = checksum_c;
    end

    generate
        if (REGISTERED) begin : g_reg
            // Reset wins over capture so no stale result survives a mid-stream reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    checksum <= 8'h00;
                    is_valid <= 1'b0;
                    flit_out <= '0;
                end else begin
                    checksum <= checksum_c;
                    is_valid <= is_valid_c;
                    flit_out <= flit_c;
                end
            end
        end else begin : g_comb
            // clk/rst are deliberately unused in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign checksum = checksum_c;
            assign is_valid = is_valid_c;
            assign flit_out = flit_c;
        end
    endgenerate
endmodule

// File: tb/tb_calculate_checksum.sv
module tb_calculate_checksum;
    import types::*;

    localparam int BODY_W = $bits(flit_t) - 8;

    logic      clk;
    logic      rst_c, rst_r;
    flit_t     flit_c, flit_r;
    checksum_t cs_c, cs_r;
    logic      vld_c, vld_r;
    flit_t     fout_c, fout_r;

    int checks = 0;
    int errors = 0;

    calculate_checksum #(.REGISTERED(1'b0)) dut_c (
        .clk(clk), .rst(rst_c), .flit_in(flit_c),
        .checksum(cs_c), .is_valid(vld_c), .flit_out(fout_c)
    );

    calculate_checksum #(.REGISTERED(1'b1)) dut_r (
        .clk(clk), .rst(rst_r), .flit_in(flit_r),
        .checksum(cs_r), .is_valid(vld_r), .flit_out(fout_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string     name;
        checksum_t cs;
        logic      vld;
        flit_t     fout;
    } exp_t;

    typedef struct {
        string     name;
        flit_t     in;
        checksum_t cs;
        logic      vld;
    } vec_t;

    exp_t exp_q[$];

    // Reference: weight each body bit by 2^(bit position within its byte), accumulate as an integer.
    function automatic checksum_t ref_checksum(input flit_t f);
        logic [BODY_W-1:0] body;
        int s;
        body = {f.header, f.payload};
        s = 0;
        for (int i = 0; i < BODY_W; i++) begin
            if (body[i]) s = s + (1 << (i % 8));
        end
        return 8'((256 - (s % 256)) % 256);
    endfunction

    function automatic flit_t seal(input flit_t f, input checksum_t c);
        flit_t r;
        r = f;
        r.checksum = c;
        return r;
    endfunction

    task automatic push_exp(input string name, input checksum_t c, input logic v, input flit_t fo);
        exp_t e;
        e.name = name; e.cs = c; e.vld = v; e.fout = fo;
        exp_q.push_back(e);
    endtask

    task automatic compare(input string name, input checksum_t c, input logic v, input flit_t fo);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty, no expectation available", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (c !== e.cs) begin
            errors++;
            $display("FAIL %s.checksum: got %h, want %h", e.name, c, e.cs);
        end
        checks++;
        if (v !== e.vld) begin
            errors++;
            $display("FAIL %s.is_valid: got %b, want %b", e.name, v, e.vld);
        end
        checks++;
        if (fo !== e.fout) begin
            errors++;
            $display("FAIL %s.flit_out: got %h, want %h", e.name, fo, e.fout);
        end
    endtask

    task automatic drive_comb(input string name, input flit_t f, input checksum_t c, input logic v);
        flit_c = f;
        push_exp(name, c, v, seal(f, c));
        #1;
        compare(name, cs_c, vld_c, fout_c);
    endtask

    // Registered DUT: drive at negedge, compare just after the following posedge.
    task automatic step_reg(input string name, input logic r, input flit_t f,
                            input checksum_t c, input logic v, input flit_t fo);
        @(negedge clk);
        rst_r  = r;
        flit_r = f;
        push_exp(name, c, v, fo);
        @(posedge clk);
        #1;
        compare(name, cs_r, vld_r, fout_r);
    endtask

    vec_t  vecs[5];
    flit_t f_zero, f_s2, f_s3, f_s4, f_ones, f;
    logic [95:0] rnd;
    checksum_t   c;

    initial begin
        rst_c = 1'b0;
        rst_r = 1'b1;
        flit_c = '0;
        flit_r = '0;

        f_zero = '0;
        f_s2 = '0; f_s2.payload.raw = 32'h0000_0001; f_s2.checksum = 8'hFF;
        f_s3 = f_s2; f_s3.checksum = 8'h00;
        f_s4 = '0; f_s4.payload.raw = 32'h0000_8080; f_s4.checksum = 8'h00;
        f_ones = '1; f_ones.checksum = 8'h00;

        vecs[0] = '{name: "all_zero",   in: f_zero, cs: 8'h00, vld: 1'b1};
        vecs[1] = '{name: "byte0_ok",   in: f_s2,   cs: 8'hFF, vld: 1'b1};
        vecs[2] = '{name: "byte0_bad",  in: f_s3,   cs: 8'hFF, vld: 1'b0};
        vecs[3] = '{name: "wrap80",     in: f_s4,   cs: 8'h00, vld: 1'b1};
        vecs[4] = '{name: "all_ones",   in: f_ones, cs: ref_checksum(f_ones),
                    vld: (ref_checksum(f_ones) == 8'h00)};

        // Combinational build: directed table.
        for (int i = 0; i < 5; i++) begin
            drive_comb(vecs[i].name, vecs[i].in, vecs[i].cs, vecs[i].vld);
        end

        // Combinational build: random flits against the model, about half carrying a correct checksum.
        for (int i = 0; i < 1000; i++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            f = rnd[$bits(flit_t)-1:0];
            c = ref_checksum(f);
            if (rnd[95]) f.checksum = c;
            drive_comb("random", f, c, f.checksum == c);
        end

        // Registered build: reset held two cycles with a non-zero input present.
        step_reg("reg_rst0", 1'b1, f_s2, 8'h00, 1'b0, '0);
        step_reg("reg_rst1", 1'b1, f_s2, 8'h00, 1'b0, '0);

        // Release: outputs stay cleared until the first capture edge.
        @(negedge clk);
        rst_r  = 1'b0;
        flit_r = f_s2;
        push_exp("reg_pre_capture", 8'h00, 1'b0, '0);
        #1;
        compare("reg_pre_capture", cs_r, vld_r, fout_r);
        push_exp("reg_first", 8'hFF, 1'b1, seal(f_s2, 8'hFF));
        @(posedge clk);
        #1;
        compare("reg_first", cs_r, vld_r, fout_r);

        step_reg("reg_bad", 1'b0, f_s3, 8'hFF, 1'b0, seal(f_s3, 8'hFF));
        step_reg("reg_ones", 1'b0, f_ones, ref_checksum(f_ones), 1'b0,
                 seal(f_ones, ref_checksum(f_ones)));

        // Mid-stream reset drops the in-flight flit.
        step_reg("reg_mid_rst", 1'b1, f_s4, 8'h00, 1'b0, '0);
        step_reg("reg_resume", 1'b0, f_s4, 8'h00, 1'b1, seal(f_s4, 8'h00));

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
